// File: rtl/vector_mac_accumulator.sv
// Four-element signed multiply-accumulate neuron: weighted sum plus bias, ReLU and
// unsigned saturation, one activation per completed vector on a one-deep valid/ready port.
module vector_mac_accumulator #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 20,
    parameter int OUT_WIDTH    = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           en,
    input  logic                           clear,
    input  logic                           new_vector,
    input  logic [1:0]                     vector_index,
    input  logic signed [DATA_WIDTH-1:0]   data_in,
    input  logic signed [ACC_WIDTH-1:0]    bias,
    input  logic                           weight_wr_en,
    input  logic [1:0]                     weight_wr_addr,
    input  logic signed [WEIGHT_WIDTH-1:0] weight_wr_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_WIDTH-1:0]           out_data,
    output logic                           out_overflow,
    output logic                           overrun,
    output logic                           index_error
);

    localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;

    logic signed [WEIGHT_WIDTH-1:0] weight_vec [4];

    // Weight slots load independently of en/clear; reading before the write gives old-weight semantics.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_weight
            logic signed [WEIGHT_WIDTH-1:0] weight_reg;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    weight_reg <= '0;
                end else if (weight_wr_en && (weight_wr_addr == 2'(gi))) begin
                    weight_reg <= weight_wr_data;
                end
            end
            assign weight_vec[gi] = weight_reg;
        end
    endgenerate

    logic signed [WEIGHT_WIDTH-1:0] weight_sel;
    logic signed [PROD_WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    acc_reg, acc_next;
    logic signed [ACC_WIDTH-1:0]    sum;
    logic signed [ACC_WIDTH-1:0]    start_sum;
    logic [1:0]                     cnt_reg, cnt_next;
    logic                           index_error_reg, index_error_next;
    logic                           accept;
    logic                           complete;
    logic [OUT_WIDTH-1:0]           res_data;
    logic                           res_ovf;
    logic                           out_valid_reg;
    logic [OUT_WIDTH-1:0]           out_data_reg;
    logic                           out_overflow_reg;
    logic                           overrun_reg;

    assign weight_sel = weight_vec[vector_index];
    assign prod       = data_in * weight_sel;
    assign prod_ext   = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    assign sum        = acc_reg + prod_ext;
    assign start_sum  = bias + prod_ext;
    assign accept     = en && new_vector && !clear;

    always_comb begin
        acc_next         = acc_reg;
        cnt_next         = cnt_reg;
        index_error_next = index_error_reg;
        complete         = 1'b0;
        if (clear) begin
            acc_next         = '0;
            cnt_next         = 2'd0;
            index_error_next = 1'b0;
        end else if (accept) begin
            if (vector_index != cnt_reg) begin
                index_error_next = 1'b1;
                // An out-of-order index 0 restarts the vector; anything else is dropped.
                if (vector_index == 2'd0) begin
                    acc_next = start_sum;
                    cnt_next = 2'd1;
                end else begin
                    acc_next = '0;
                    cnt_next = 2'd0;
                end
            end else if (cnt_reg == 2'd0) begin
                acc_next = start_sum;
                cnt_next = 2'd1;
            end else if (cnt_reg == 2'd3) begin
                complete = 1'b1;
                acc_next = '0;
                cnt_next = 2'd0;
            end else begin
                acc_next = sum;
                cnt_next = cnt_reg + 2'd1;
            end
        end
    end

    // ReLU then saturate to the unsigned output range.
    always_comb begin
        res_data = '0;
        res_ovf  = 1'b0;
        if (!sum[ACC_WIDTH-1]) begin
            if (|sum[ACC_WIDTH-2:OUT_WIDTH]) begin
                res_data = '1;
                res_ovf  = 1'b1;
            end else begin
                res_data = sum[OUT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg          <= '0;
            cnt_reg          <= 2'd0;
            index_error_reg  <= 1'b0;
            out_valid_reg    <= 1'b0;
            out_data_reg     <= '0;
            out_overflow_reg <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            acc_reg         <= acc_next;
            cnt_reg         <= cnt_next;
            index_error_reg <= index_error_next;
            if (clear) begin
                out_valid_reg <= 1'b0;
                overrun_reg   <= 1'b0;
            end else if (complete) begin
                if (!out_valid_reg || out_ready) begin
                    out_valid_reg    <= 1'b1;
                    out_data_reg     <= res_data;
                    out_overflow_reg <= res_ovf;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;
    assign out_overflow = out_overflow_reg;
    assign overrun      = overrun_reg;
    assign index_error  = index_error_reg;

endmodule

// File: doc/vector_mac_accumulator.md
# vector_mac_accumulator

Downstream consumer of the per-vector element index stream (`vector_index`, `new_vector`) in the neuron datapath. It multiplies each incoming signed element by a per-index weight and accumulates four products plus a bias. It then applies ReLU and unsigned saturation, and presents one neuron activation per completed 4-element vector on a valid/ready output port. It also flags index sequencing errors and output overruns.

## Interface
- `DATA_WIDTH`, 8: signed element width.
- `WEIGHT_WIDTH`, 8: signed weight width.
- `ACC_WIDTH`, 20: signed accumulator width. Must be ≥ `DATA_WIDTH+WEIGHT_WIDTH+2`.
- `OUT_WIDTH`, 8: unsigned activation width.

- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: accumulate enable. When low, accumulator, element count and element strobes are frozen or ignored.
- `clear` in 1: synchronous abort.
- `new_vector` in 1: element strobe.
- `vector_index` in 2: index of the strobed element, 0..3.
- `data_in` in `DATA_WIDTH`: signed element, valid when `new_vector`=1.
- `bias` in `ACC_WIDTH`: signed bias, sampled on index-0 accept.
- `weight_wr_en` in 1: weight write strobe.
- `weight_wr_addr` in 2: weight slot.
- `weight_wr_data` in `WEIGHT_WIDTH`: signed weight.
- `out_valid` out 1: activation available.
- `out_ready` in 1: consumer accepts.
- `out_data` out `OUT_WIDTH`: activation.
- `out_overflow` out 1: `out_data` was saturated high. Qualified by `out_valid`.
- `overrun` out 1: sticky; a completed result was dropped.
- `index_error` out 1: sticky; `vector_index` mismatched the expected count.

## Operation
- **Weight file:** 4 × `WEIGHT_WIDTH` registers, written on `weight_wr_en` regardless of `en`/`clear`.
- **Accept condition:** an element is accepted when `en` & `new_vector` & !`clear`. Weight used is `w[vector_index]`. Product is full-precision signed, sign-extended to `ACC_WIDTH`.
- **Expected-index counter** `cnt` (2 bits):
  - Match (`vector_index == cnt`):
    - index 0: `acc <= bias + prod`.
    - index 1, 2: `acc <= acc + prod`.
    - index 3: completion. `sum = acc + prod`; `cnt` wraps to 0.
    - Otherwise `cnt` increments.
  - Mismatch: set `index_error`.
    - If `vector_index == 0`: treat as a fresh index-0 accept (`acc <= bias + prod`, `cnt <= 1`).
    - Else: discard the element, `acc <= 0`, `cnt <= 0`.
- **Completion:** ReLU, then saturate.
  - `sum < 0` → 0.
  - `sum > 2^OUT_WIDTH−1` → all-ones, with `out_overflow`=1.
  - Else `sum[OUT_WIDTH−1:0]`, with `out_overflow`=0.
- **Output register** (one deep):
  - Completion with `out_valid`=0, or with `out_valid`=1 & `out_ready`=1: load new result, `out_valid` stays/goes 1.
  - Completion with `out_valid`=1 & `out_ready`=0: new result dropped, `overrun` set, held output unchanged.
  - No completion & `out_ready`=1: `out_valid` goes 0.
  - `out_data`/`out_overflow` hold while `out_valid`=1 & `out_ready`=0.
- **Handshake:** operates independently of `en`.
- **`clear`:** `acc`, `cnt`, `out_valid`, `overrun`, `index_error` go to 0. Weights are unaffected. `clear` has priority over an accept in the same cycle.
- **Reset:** all registers (including weights), `out_data`, `out_overflow` go to 0.

## Timing
- Accept and accumulate take effect at the edge where the strobe is sampled.
- `out_valid` rises 1 cycle after the index-3 strobe edge.
- Back-to-back vectors (strobe every cycle) are sustained at 1 result per 4 cycles.
- A weight write in the same cycle as an accept at that address: the old weight is used. The new weight applies from the next cycle.
- `reset_n` deassertion mid-vector: the partial sum is lost and the block waits for index 0.
- Sticky flags are set at the edge following the triggering event.

## Test plan
- Weights {1,2,3,4}, bias 0, data 1,2,3,4 on consecutive strobes, `out_ready`=1 → `out_data`=30, `out_overflow`=0, `out_valid` high 1 cycle after the 4th strobe.
- Same weights, data 10,20,30,40 → sum 300 → `out_data`=255, `out_overflow`=1. Weights all −1, data 5,5,5,5, bias 3 → `out_data`=0.
- Hold `out_ready`=0, stream two vectors (30 then 20) → first result held at 30, `overrun`=1 after the second completion. Then `out_ready`=1 → 30 consumed, `out_valid`=0.
- Index sequence 0,1,3 → `index_error`=1, the index-3 element is discarded. Following 0,1,2,3 with data 1,2,3,4 → `out_data`=30.
- Assert `clear` on an index-2 strobe, or `reset_n`=0 mid-vector → that element is ignored, `out_valid`=0, flags 0. Next full vector produces the correct result; weights survive `clear` only.
- `en`=0 during strobes → no accumulation. Weight write to slot 2 (value 5) concurrent with the index-2 accept → the old weight is used, and the next vector uses 5.
